// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline encodings: writeback source select, load/store funct3,
// MW-stage FSM states and the data-memory request payload.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_LAUI = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } mw_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   is_misaligned = lo[0];
      2'b10:   is_misaligned = |lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable / store-lane replication and load lane extract + extension.
// Misaligned halfword/word accesses fall back to the aligned lane.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_load_data,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = i_load_data[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_load_data[15:8];
      2'd2:    w_byte = i_load_data[23:16];
      2'd3:    w_byte = i_load_data[31:24];
      default: ;
    endcase
    w_half = i_addr_lo[1] ? i_load_data[31:16] : i_load_data[15:0];
  end

  always_comb begin
    o_load_ext = i_load_data;
    case (i_funct3)
      F3_B:    o_load_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_ext = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_ext = {24'd0, w_byte};
      F3_HU:   o_load_ext = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mw_stage.sv
// RV32I memory/writeback stage: req/gnt/rvalid data-memory access with timeout,
// load alignment, writeback mux. Define MW_MISALIGN_TRAP_EN to trap misaligned accesses.
module mw_stage
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCMW,
  input  logic        RegWriteMW,
  input  logic [1:0]  ResultSrcMW,
  input  logic        MemWriteMW,
  input  logic [31:0] ALUResultMW,
  input  logic [31:0] LauiPCMW,
  input  logic [31:0] RD2MW,
  input  logic [31:0] InstrMW,
  input  logic [4:0]  RdMW,
  input  logic [31:0] PC4MW,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic [31:0] err_pc_o
);

  mw_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_done, r_bus_err;
  logic [31:0]      r_done_pc, r_err_pc;

  logic        w_done, w_store, w_load, w_mem_op, w_misalign;
  logic        w_req, w_store_cpl, w_load_cpl, w_timeout, w_stall, w_rf_we;
  logic [2:0]  w_funct3;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_ext, w_result;
  logic        w_unused_instr;
  dmem_req_t   w_dreq;

  assign w_funct3       = InstrMW[14:12];
  assign w_unused_instr = ^{InstrMW[31:15], InstrMW[11:0]};

  // Done only blocks re-issue while the same instruction is still presented.
  assign w_done   = r_done & (PCMW == r_done_pc);
  assign w_store  = MemWriteMW;
  assign w_load   = (ResultSrcMW == RES_MEM) & ~MemWriteMW;
  assign w_mem_op = (MemWriteMW | (ResultSrcMW == RES_MEM)) & ~w_done;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef MW_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & (r_state == ST_IDLE) &
                      is_misaligned(w_funct3, ALUResultMW[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  lsu_align u_align (
    .i_funct3     (w_funct3),
    .i_addr_lo    (ALUResultMW[1:0]),
    .i_store_data (RD2MW),
    .i_load_data  (dmem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_ext   (w_load_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; a completing store or rvalid takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_req       = 1'b0;
    w_store_cpl = 1'b0;
    w_load_cpl  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op && !w_misalign) begin
          w_req = 1'b1;
          if (!dmem_gnt_i)   w_state_nxt = ST_WAIT_GNT;
          else if (w_store)  w_store_cpl = 1'b1;
          else               w_state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_GNT: begin
        w_req     = 1'b1;
        w_cnt_nxt = w_cnt_inc;
        if (dmem_gnt_i && w_store) begin
          w_store_cpl = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (dmem_gnt_i) begin
          w_state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        w_cnt_nxt = w_cnt_inc;
        if (dmem_rvalid_i) begin
          w_load_cpl  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_done_pc <= '0;
      r_bus_err <= 1'b0;
      r_err_pc  <= '0;
    end else begin
      r_bus_err <= w_timeout | w_misalign;
      if (w_timeout || w_misalign) r_err_pc <= PCMW;
      if (w_store_cpl || w_load_cpl || w_timeout || w_misalign) begin
        r_done    <= 1'b1;
        r_done_pc <= PCMW;
      end else if (r_done && (PCMW != r_done_pc)) begin
        r_done <= 1'b0;
      end
    end
  end

  always_comb begin
    w_result = ALUResultMW;
    case (ResultSrcMW)
      RES_MEM:  w_result = w_load_ext;
      RES_PC4:  w_result = PC4MW;
      RES_LAUI: w_result = LauiPCMW;
      default:  ;
    endcase
  end

  assign w_stall = w_mem_op & ~w_misalign & ~(w_store_cpl | w_load_cpl) & ~w_timeout;
  assign w_rf_we = RegWriteMW & (RdMW != 5'd0) & ~w_stall & ~w_timeout & ~w_misalign &
                   (~w_load | w_load_cpl);

  assign w_dreq = '{we: w_req & MemWriteMW, addr: {ALUResultMW[31:2], 2'b00},
                    be: w_be, wdata: w_wdata};

  assign dmem_req_o   = w_req & ~reset;
  assign dmem_we_o    = w_dreq.we;
  assign dmem_addr_o  = w_dreq.addr;
  assign dmem_be_o    = w_dreq.be;
  assign dmem_wdata_o = w_dreq.wdata;
  assign stall_o      = w_stall & ~reset;
  assign rf_we_o      = w_rf_we & ~reset;
  assign rf_waddr_o   = RdMW;
  assign rf_wdata_o   = w_result;
  assign bus_err_o    = r_bus_err;
  assign err_pc_o     = r_err_pc;

endmodule

// File: tb/tb_mw_stage.sv
// Directed self-checking bench for mw_stage (default build and MW_MISALIGN_TRAP_EN build).
module tb_mw_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCMW, ALUResultMW, LauiPCMW, RD2MW, InstrMW, PC4MW;
  logic        RegWriteMW, MemWriteMW;
  logic [1:0]  ResultSrcMW;
  logic [4:0]  RdMW;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        rf_we_o, stall_o, bus_err_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, err_pc_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mw_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .PCMW(PCMW), .RegWriteMW(RegWriteMW),
    .ResultSrcMW(ResultSrcMW), .MemWriteMW(MemWriteMW), .ALUResultMW(ALUResultMW),
    .LauiPCMW(LauiPCMW), .RD2MW(RD2MW), .InstrMW(InstrMW), .RdMW(RdMW), .PC4MW(PC4MW),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .stall_o(stall_o),
    .bus_err_o(bus_err_o), .err_pc_o(err_pc_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic regw, input logic [1:0] rsrc,
                       input logic memw, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] rd);
    PCMW        = pc;
    PC4MW       = pc + 32'd4;
    RegWriteMW  = regw;
    ResultSrcMW = rsrc;
    MemWriteMW  = memw;
    InstrMW     = {17'd0, f3, 12'h003};
    ALUResultMW = alu;
    RD2MW       = rd2;
    RdMW        = rd;
  endtask

  initial begin
    reset = 1'b1; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    LauiPCMW = 32'hABCD_0000;
    drive(32'h80, 1'b1, RES_MEM, 1'b0, F3_W, 32'h2000, 32'h0, 5'd3);
    #3;
    chk1("rst_req", dmem_req_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_rf_we", rf_we_o, 1'b0);
    chk1("rst_bus_err", bus_err_o, 1'b0);
    chk32("rst_err_pc", err_pc_o, 32'h0);

    // ALU / PC+4 / LUI-AUIPC writeback, and x0 suppression
    tick(); reset = 1'b0;
    drive(32'h100, 1'b1, RES_ALU, 1'b0, F3_W, 32'h1234, 32'h0, 5'd5);
    #2;
    chk1("alu_we", rf_we_o, 1'b1);
    chk32("alu_waddr", 32'(rf_waddr_o), 32'd5);
    chk32("alu_wdata", rf_wdata_o, 32'h1234);
    chk1("alu_stall", stall_o, 1'b0);
    chk1("alu_req", dmem_req_o, 1'b0);
    tick(); drive(32'h104, 1'b1, RES_PC4, 1'b0, F3_W, 32'h1234, 32'h0, 5'd6); #2;
    chk32("pc4_wdata", rf_wdata_o, 32'h108);
    tick(); drive(32'h108, 1'b1, RES_LAUI, 1'b0, F3_W, 32'h1234, 32'h0, 5'd6); #2;
    chk32("laui_wdata", rf_wdata_o, 32'hABCD_0000);
    tick(); drive(32'h10C, 1'b1, RES_ALU, 1'b0, F3_W, 32'h1234, 32'h0, 5'd0); #2;
    chk1("x0_we", rf_we_o, 1'b0);

    // SB granted in the request cycle, then held: no re-issue
    tick(); dmem_gnt_i = 1'b1;
    drive(32'h110, 1'b0, RES_ALU, 1'b1, F3_B, 32'h1003, 32'hAABBCCDD, 5'd0); #2;
    chk1("sb_req", dmem_req_o, 1'b1);
    chk1("sb_we", dmem_we_o, 1'b1);
    chk32("sb_addr", dmem_addr_o, 32'h1000);
    chk32("sb_be", 32'(dmem_be_o), 32'h8);
    chk32("sb_wdata", dmem_wdata_o, 32'hDDDDDDDD);
    chk1("sb_stall", stall_o, 1'b0);
    chk1("sb_rf_we", rf_we_o, 1'b0);
    tick(); #2;
    chk1("sb_hold_req", dmem_req_o, 1'b0);
    tick(); drive(32'h118, 1'b0, RES_ALU, 1'b1, F3_H, 32'h1002, 32'h11223344, 5'd0); #2;
    chk32("sh_be", 32'(dmem_be_o), 32'hC);
    chk32("sh_wdata", dmem_wdata_o, 32'h33443344);

    // LB: no gnt, gnt, wait, rvalid
    tick(); dmem_gnt_i = 1'b0;
    drive(32'h120, 1'b1, RES_MEM, 1'b0, F3_B, 32'h2001, 32'h0, 5'd7); #2;
    chk1("lb_c0_req", dmem_req_o, 1'b1);
    chk1("lb_c0_we", dmem_we_o, 1'b0);
    chk1("lb_c0_stall", stall_o, 1'b1);
    chk1("lb_c0_rf_we", rf_we_o, 1'b0);
    tick(); dmem_gnt_i = 1'b1; #2;
    chk1("lb_c1_req", dmem_req_o, 1'b1);
    chk1("lb_c1_stall", stall_o, 1'b1);
    tick(); dmem_gnt_i = 1'b0; #2;
    chk1("lb_c2_req", dmem_req_o, 1'b0);
    chk1("lb_c2_stall", stall_o, 1'b1);
    chk1("lb_c2_rf_we", rf_we_o, 1'b0);
    tick(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_8000; #2;
    chk1("lb_c3_stall", stall_o, 1'b0);
    chk1("lb_c3_rf_we", rf_we_o, 1'b1);
    chk32("lb_c3_waddr", 32'(rf_waddr_o), 32'd7);
    chk32("lb_c3_wdata", rf_wdata_o, 32'hFFFFFF80);
    tick(); dmem_rvalid_i = 1'b0; #2;
    chk1("lb_c4_rf_we", rf_we_o, 1'b0);
    chk1("lb_c4_req", dmem_req_o, 1'b0);

    // LHU and LH on the upper halfword
    tick(); dmem_gnt_i = 1'b1;
    drive(32'h130, 1'b1, RES_MEM, 1'b0, F3_HU, 32'h2002, 32'h0, 5'd8); #2;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_0000; #2;
    chk1("lhu_rf_we", rf_we_o, 1'b1);
    chk32("lhu_wdata", rf_wdata_o, 32'h0000_8001);
    tick(); dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1;
    drive(32'h138, 1'b1, RES_MEM, 1'b0, F3_H, 32'h2002, 32'h0, 5'd8); #2;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; #2;
    chk32("lh_wdata", rf_wdata_o, 32'hFFFF_8001);

    // Timeout: gnt never arrives
    tick(); dmem_rvalid_i = 1'b0;
    drive(32'h140, 1'b1, RES_MEM, 1'b0, F3_W, 32'h2000, 32'h0, 5'd9); #2;
    chk1("to_c0_stall", stall_o, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick(); #2;
      chk1("to_wait_stall", stall_o, 1'b1);
    end
    tick(); #2;
    chk1("to_abort_stall", stall_o, 1'b0);
    chk1("to_abort_rf_we", rf_we_o, 1'b0);
    tick(); #2;
    chk1("to_bus_err", bus_err_o, 1'b1);
    chk32("to_err_pc", err_pc_o, 32'h140);
    chk1("to_no_reissue", dmem_req_o, 1'b0);
    tick(); #2;
    chk1("to_pulse_end", bus_err_o, 1'b0);
    chk32("to_err_pc_held", err_pc_o, 32'h140);

    // Reset in WAIT_RSP, then a stray rvalid against a fresh load
    tick(); dmem_gnt_i = 1'b1;
    drive(32'h150, 1'b1, RES_MEM, 1'b0, F3_W, 32'h2004, 32'h0, 5'd10); #2;
    tick(); dmem_gnt_i = 1'b0; #2;
    chk1("rsp_stall", stall_o, 1'b1);
    reset = 1'b1; #1;
    chk1("midrst_stall", stall_o, 1'b0);
    chk1("midrst_req", dmem_req_o, 1'b0);
    chk1("midrst_rf_we", rf_we_o, 1'b0);
    tick(); reset = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    drive(32'h160, 1'b1, RES_MEM, 1'b0, F3_W, 32'h2008, 32'h0, 5'd11); #2;
    chk1("stray_rf_we", rf_we_o, 1'b0);
    chk1("stray_req", dmem_req_o, 1'b1);
    chk1("stray_stall", stall_o, 1'b1);
    tick(); dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1; #2;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D; #2;
    chk32("lw_wdata", rf_wdata_o, 32'hCAFE_F00D);
    chk1("lw_rf_we", rf_we_o, 1'b1);

    // Misaligned word access
    tick(); dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
    drive(32'h170, 1'b1, RES_MEM, 1'b0, F3_W, 32'h3002, 32'h0, 5'd12); #2;
`ifdef MW_MISALIGN_TRAP_EN
    chk1("mis_req", dmem_req_o, 1'b0);
    chk1("mis_stall", stall_o, 1'b0);
    chk1("mis_rf_we", rf_we_o, 1'b0);
    tick(); #2;
    chk1("mis_bus_err", bus_err_o, 1'b1);
    chk32("mis_err_pc", err_pc_o, 32'h170);
    chk1("mis_no_req", dmem_req_o, 1'b0);
`else
    chk1("mis_req", dmem_req_o, 1'b1);
    chk32("mis_addr", dmem_addr_o, 32'h3000);
    chk1("mis_stall", stall_o, 1'b1);
    tick(); dmem_gnt_i = 1'b1; #2;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678; #2;
    chk32("mis_lw_wdata", rf_wdata_o, 32'h1234_5678);
    tick(); dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1;
    drive(32'h178, 1'b1, RES_MEM, 1'b0, F3_H, 32'h3003, 32'h0, 5'd12); #2;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7001_1234; #2;
    chk32("mis_lh_wdata", rf_wdata_o, 32'h0000_7001);
    chk1("mis_bus_err", bus_err_o, 1'b0);
`endif

    tick(); dmem_rvalid_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mw_stage.md
Name: mw_stage

Overview:
- Combined memory/writeback stage of the RV32I pipeline. Sits directly downstream of the EX→MW pipeline register and consumes its outputs.
- Performs load/store accesses over a req/gnt/rvalid data-memory handshake, aligns and sign-extends load data, selects the writeback result, and drives the register-file write port.
- Asserts a stall back to the hazard unit while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT_GNT+WAIT_RSP before the access is aborted with bus_err_o
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- PCMW  in  32  PC of the instruction in this stage (error reporting)
- RegWriteMW  in  1  register write enable
- ResultSrcMW  in  2  00 ALU, 01 memory load, 10 PC+4, 11 LauiPC
- MemWriteMW  in  1  store
- ALUResultMW  in  32  effective address / ALU result
- LauiPCMW  in  32  LUI/AUIPC result
- RD2MW  in  32  store data
- InstrMW  in  32  instruction; funct3 = [14:12]
- RdMW  in  5  destination register
- PC4MW  in  32  PC+4
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address ({ALUResultMW[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load data
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- stall_o  out  1  freeze upstream stages and the MW register
- bus_err_o  out  1  one-cycle pulse on timeout
- err_pc_o  out  32  PC of the faulting access; held until the next error

Behaviour:
- Classification: mem_op = MemWriteMW | (ResultSrcMW==01); load = ResultSrcMW==01 & !MemWriteMW.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
  - IDLE + mem_op: dmem_req_o=1 combinationally. gnt in the same cycle: store completes (stay IDLE); load → WAIT_RSP. No gnt → WAIT_GNT.
  - WAIT_GNT: req held. Request fields stay stable because the inputs are frozen by stall_o. On gnt: store → IDLE (done); load → WAIT_RSP.
  - WAIT_RSP: req=0. On rvalid → IDLE; load writes back this cycle.
  - rvalid in the same cycle as gnt is not legal; the earliest rvalid is the cycle after gnt.
  - A done flag blocks re-issue of the same instruction in the cycle where the stall releases. It clears when the frozen inputs advance.
- stall_o = mem_op & !(store completing | load rvalid this cycle) & !timeout_abort.
- Timeout:
  - Counter resets to 0 in IDLE and increments each cycle in WAIT_GNT or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES: pulse bus_err_o, latch err_pc_o=PCMW, return to IDLE, drop stall, suppress writeback.
  - A late rvalid/gnt in IDLE with no pending op is ignored.
- Stores, by funct3:
  - SB: be = 0001 << addr[1:0], wdata = {4{RD2[7:0]}}.
  - SH: be = 0011 << {addr[1],1'b0}, wdata = {2{RD2[15:0]}}.
  - SW: be = 1111.
- Loads: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Writeback:
  - rf_we_o = RegWriteMW & RdMW!=0 & !stall_o & !abort. A load writes only in its rvalid cycle.
  - rf_wdata_o is muxed by ResultSrcMW.
  - rf_waddr_o = RdMW.
- Reset (asynchronous): state IDLE, counter 0, done 0, err_pc_o 0, bus_err_o 0. Combinational outputs are forced to 0 while reset is high: dmem_req_o, stall_o, rf_we_o.
- Reset mid-access abandons the access; any later rvalid is ignored.

Optional Feature:
- Macro: MW_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, issues no request.
  - Pulses bus_err_o and latches err_pc_o in the same cycle.
  - No stall, no writeback.
- Undefined:
  - Low address bits are ignored for lane selection of misaligned halfword/word accesses. The access proceeds at the aligned address (halfword uses addr[1]).

Decomposition:
- Shared package rv32_pkg:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4, RES_LAUI).
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state typedef.
- One sub-module, lsu_align: purely combinational byte-enable/store-replication and load extract/extend logic. The FSM, counter and writeback mux stay in mw_stage.

Test Plan:
- ALU op, ResultSrc=00, Rd=5, ALUResult=0x1234 → rf_we=1, waddr=5, wdata=0x1234, stall=0, no req.
- SB, addr=0x1003, RD2=0xAABBCCDD, gnt same cycle → be=1000, wdata=0xDDDDDDDD, stall=0, rf_we=0.
- LB, addr=0x2001, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x0000_8000 → stall high 3 cycles, then rf_wdata=0xFFFFFF80, single rf_we pulse.
- LHU, addr=0x2002, rdata=0x8001_0000 → rf_wdata=0x00008001.
- Load, gnt never asserted, TIMEOUT_CYCLES=16 → bus_err pulse after 16 cycles, err_pc=PCMW, stall drops, no rf_we.
- Reset asserted while in WAIT_RSP, then a stray rvalid → state IDLE, no rf_we, outputs 0. With MW_MISALIGN_TRAP_EN: LW at addr 0x3002 → no req, bus_err pulse.
